// File: rtl/detector_share_arbiter.sv
// detector_share_arbiter
//   Four serial channels share one 1011 sequence detector (overlapping
//   matches allowed). A round-robin arbiter picks one requesting channel per
//   cycle. The single next-state function then advances that channel's saved
//   state. A detection produces a registered one-cycle hit pulse, and hit_id
//   reports the channel that caused it.
//
//   Optional feature macro: DETECT_CNT_EN
//     When it is defined, the block adds an 8-bit saturating detection
//     counter on port hit_cnt.
//
//   Per-channel detector states:
//     state | meaning
//     S0    | idle, no useful prefix seen
//     S1    | seen "1"
//     S2    | seen "10"
//     S3    | seen "101"
//     S4    | seen "1011" (detected); w[k] is high while here
//   Encodings 101..111 are unreachable. A granted channel in one of them
//   recovers to S0.

module detector_share_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] j,
  output logic [3:0] gnt,
  output logic [3:0] w,
  output logic       hit,
  output logic [1:0] hit_id
`ifdef DETECT_CNT_EN
  ,
  output logic [7:0] hit_cnt
`endif
);

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_t;

  // The state is stored as raw bits, so the unused encodings stay visible
  // to the recovery path.
  logic [2:0] st [4];
  logic [1:0] ptr;

  logic       gnt_any;
  logic [1:0] gnt_idx;
  logic [1:0] cand;
  logic [2:0] cur_st;
  logic       cur_j;
  logic [2:0] nxt_st;
  logic       detect;

  function automatic logic [2:0] next_state(input logic [2:0] s, input logic b);
    logic [2:0] n;
    n = S0;
    case (s)
      S0:      n = b ? S1 : S0;
      S1:      n = b ? S1 : S2;
      S2:      n = b ? S3 : S0;
      S3:      n = b ? S4 : S2;
      S4:      n = b ? S1 : S2;
      default: n = S0;
    endcase
    return n;
  endfunction

  // Round-robin search starting at ptr; the first requester found wins.
  always_comb begin
    gnt     = 4'b0000;
    gnt_any = 1'b0;
    gnt_idx = ptr;
    cand    = ptr;
    for (int i = 0; i < 4; i++) begin
      cand = 2'(ptr + 2'(i));
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  // Shared next-state logic, fed only by the granted channel.
  always_comb begin
    cur_st = st[gnt_idx];
    cur_j  = j[gnt_idx];
    nxt_st = next_state(cur_st, cur_j);
    detect = gnt_any && (cur_st != S4) && (nxt_st == S4);
  end

  // Moore output: decode each channel's saved state.
  always_comb begin
    w = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w[i] = (st[i] == S4);
    end
  end

  // Update the granted channel's state, advance the pointer, and register the hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        st[i] <= S0;
      end
      ptr    <= 2'd0;
      hit    <= 1'b0;
      hit_id <= 2'd0;
    end else begin
      hit <= 1'b0;
      if (gnt_any) begin
        st[gnt_idx] <= nxt_st;
        ptr         <= gnt_idx + 2'd1;
        if (detect) begin
          hit    <= 1'b1;
          hit_id <= gnt_idx;
        end
      end
    end
  end

`ifdef DETECT_CNT_EN
  // Count the cycles in which hit is high; hold at 255 instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt <= 8'd0;
    end else if (hit && (hit_cnt != 8'hFF)) begin
      hit_cnt <= hit_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_detector_share_arbiter.sv
// Testbench for detector_share_arbiter.
// The stimulus pushes a hand-computed expectation each cycle, and a
// monitor pops and compares it. Define DETECT_CNT_EN to also exercise
// the saturating counter.

module tb_detector_share_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] j;
  logic [3:0] gnt;
  logic [3:0] w;
  logic       hit;
  logic [1:0] hit_id;
`ifdef DETECT_CNT_EN
  logic [7:0] hit_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] w;
    logic       hit;
    logic [1:0] hid;
  } exp_t;

  exp_t exp_q[$];

  detector_share_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .j      (j),
    .gnt    (gnt),
    .w      (w),
    .hit    (hit),
    .hit_id (hit_id)
`ifdef DETECT_CNT_EN
    ,
    .hit_cnt(hit_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs at the falling edge. Push the values expected
  // in this cycle: gnt follows the new inputs; w and hit reflect the
  // previous rising edge.
  task automatic step(input logic rb, input logic [3:0] r, input logic [3:0] jj,
                      input logic [3:0] eg, input logic [3:0] ew,
                      input logic eh, input logic [1:0] eid);
    exp_t e;
    @(negedge clk);
    rst = rb;
    req = r;
    j   = jj;
    e.gnt = eg;
    e.w   = ew;
    e.hit = eh;
    e.hid = eid;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rb, input logic [3:0] r, input logic [3:0] jj);
    @(negedge clk);
    rst = rb;
    req = r;
    j   = jj;
  endtask

  // Monitor: compare the DUT against the queued expectation every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("gnt", 8'(gnt), 8'(e.gnt));
        chk("w",   8'(w),   8'(e.w));
        chk("hit", 8'(hit), 8'(e.hit));
        if (e.hit) chk("hit_id", 8'(hit_id), 8'(e.hid));
      end
    end
  end

  initial begin
    rst = 1'b0;
    req = 4'b0000;
    j   = 4'b0000;

    // Reset state: gnt stays combinational with ptr=0.
    step(0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 0, 0);
    step(0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 0, 0);

    // Single channel 0: 1,0,1,1.
    step(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 0, 0);
    step(1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 0, 0);
    step(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 0, 0);
    step(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 0, 0);
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1, 0);
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 0);

    // Overlap on channel 2: 1,0,1,1,0,1,1 (ptr=1, ch0 still in S4).
    step(1, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 0, 0);
    step(1, 4'b0100, 4'b0000, 4'b0100, 4'b0001, 0, 0);
    step(1, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 0, 0);
    step(1, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 0, 0);
    step(1, 4'b0100, 4'b0000, 4'b0100, 4'b0101, 1, 2);
    step(1, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 0, 0);
    step(1, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 0, 0);
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 1, 2);
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 0, 0);

    // Round-robin with req=1111 from reset; non-granted j bits differ from the granted bit.
    step(0, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 0, 0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        logic [3:0] onehot;
        onehot = 4'(1 << c);
        step(1, 4'b1111, (r == 1) ? ~onehot : onehot, onehot, 4'b0000, 0, 0);
      end
    end
    step(1, 4'b1111, 4'b0001, 4'b0001, 4'b0000, 0, 0);
    step(1, 4'b1111, 4'b0010, 4'b0010, 4'b0001, 1, 0);
    step(1, 4'b1111, 4'b0100, 4'b0100, 4'b0011, 1, 1);
    step(1, 4'b1111, 4'b1000, 4'b1000, 4'b0111, 1, 2);
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1, 3);

    // Starvation/hold: ch0 mid-pattern, req=0101, ptr=1.
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    step(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 0, 0);
    step(1, 4'b0101, 4'b0000, 4'b0100, 4'b0000, 0, 0);
    step(1, 4'b0101, 4'b0000, 4'b0001, 4'b0000, 0, 0);
    step(1, 4'b0101, 4'b0101, 4'b0100, 4'b0000, 0, 0);
    step(1, 4'b0101, 4'b0001, 4'b0001, 4'b0000, 0, 0);
    step(1, 4'b0101, 4'b0000, 4'b0100, 4'b0000, 0, 0);
    step(1, 4'b0101, 4'b0001, 4'b0001, 4'b0000, 0, 0);
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1, 0);

    // Reset mid-operation with ch1 in S3.
    step(1, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 0, 0);
    step(1, 4'b0010, 4'b0000, 4'b0010, 4'b0001, 0, 0);
    step(1, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 0, 0);
    step(0, 4'b1010, 4'b0000, 4'b0010, 4'b0000, 0, 0);
    step(1, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 0, 0);
    step(1, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 0, 0);
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);

`ifdef DETECT_CNT_EN
    // 300 detections on channel 0; the counter must stop at 255.
    drive(0, 4'b0000, 4'b0000);
    #2 chk("hit_cnt_reset0", hit_cnt, 8'd0);
    drive(1, 4'b0001, 4'b0001);
    drive(1, 4'b0001, 4'b0000);
    drive(1, 4'b0001, 4'b0001);
    drive(1, 4'b0001, 4'b0001);
    for (int k = 1; k < 300; k++) begin
      drive(1, 4'b0001, 4'b0000);
      drive(1, 4'b0001, 4'b0001);
      drive(1, 4'b0001, 4'b0001);
    end
    drive(1, 4'b0000, 4'b0000);
    drive(1, 4'b0000, 4'b0000);
    #2 chk("hit_cnt_sat", hit_cnt, 8'd255);
    drive(1, 4'b0000, 4'b0000);
    #2 chk("hit_cnt_hold", hit_cnt, 8'd255);
    drive(0, 4'b0000, 4'b0000);
    #2 chk("hit_cnt_reset", hit_cnt, 8'd0);
`endif

    @(negedge clk);
    #5;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/detector_share_arbiter.md
DETECTOR_SHARE_ARBITER -- requirements
Module: detector_share_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. Ports are named clk and rst.
REQ-002 Port clk SHALL be: input, 1 bit, rising-edge clock.
REQ-003 Port rst SHALL be: input, 1 bit, asynchronous active-low reset (0 = reset).
REQ-004 Port req SHALL be: input, 4 bits, per-channel request; bit k set means channel k presents a serial bit this cycle.
REQ-005 Port j SHALL be: input, 4 bits, per-channel serial data bit; j[k] is meaningful only while req[k]=1.
REQ-006 Port gnt SHALL be: output, 4 bits, one-hot-or-zero grant; combinational from req and the round-robin pointer.
REQ-007 Port w SHALL be: output, 4 bits, per-channel Moore output; w[k]=1 when channel k's saved state is S4.
REQ-008 Port hit SHALL be: output, 1 bit, registered one-cycle pulse on a detection.
REQ-009 Port hit_id SHALL be: output, 2 bits, registered index of the channel that caused hit.

Function
REQ-010 The block SHALL hold one 3-bit state register per channel (st0..st3); encodings S0=000, S1=001, S2=010, S3=011, S4=100.
REQ-011 Next-state logic SHALL be a single shared instance, applied only to the granted channel's state and j bit.
REQ-012 Transitions for j=1 / j=0 SHALL be: S0->S1/S0, S1->S1/S2, S2->S3/S0, S3->S4/S2, S4->S1/S2 (detects 1011, with overlap).
REQ-013 Unused encodings 101..111 SHALL go to S0 when granted, regardless of j.
REQ-014 Arbitration SHALL be round-robin: the search starts at channel ptr and proceeds ptr, ptr+1, ... modulo 4; the first requesting channel is granted.
REQ-015 After a grant to channel k, ptr SHALL become (k+1) mod 4 at the clock edge; with req=0000, gnt=0000 and ptr holds.
REQ-016 At most one channel's state SHALL update per clock edge; non-granted channels hold state even when their req is set.
REQ-017 Latency: a granted bit SHALL update the channel state at that edge; w reflects the new state in the following cycle.
REQ-018 hit SHALL be 1 for exactly one cycle after an edge at which the granted channel's state changed from any non-S4 value to S4; hit_id SHALL then equal that channel.
REQ-019 A granted channel that is already in S4 SHALL leave S4 (to S1 or S2), so a repeated S4 entry can occur only after it has left S4.
REQ-020 When hit=0, hit_id SHALL hold its last value.
REQ-021 Changes to req or j that occur while a channel is not granted SHALL have no effect on that channel.

Reset
REQ-022 While rst=0, all per-channel states SHALL be S0, ptr=0, hit=0, hit_id=00, and w=0000, asynchronously; gnt remains combinational from req with ptr=0.
REQ-023 A reset asserted mid-sequence SHALL discard all partial matches; after release, a full 1011 is required per channel.

Configuration
REQ-024 When the macro DETECT_CNT_EN is defined, the block SHALL add output hit_cnt (8 bits).
REQ-025 With DETECT_CNT_EN, hit_cnt SHALL increment on every cycle in which hit=1, SHALL saturate at 255, and SHALL reset to 0.
REQ-026 Without DETECT_CNT_EN, the hit_cnt port and its counter SHALL NOT exist; all other behaviour is identical.

Verification
REQ-027 Single channel: hold req=0001 and drive j[0]=1,0,1,1 over four cycles. Required response: w[0]=1 after the fourth edge, hit=1 with hit_id=00 for one cycle, and gnt=0001 every cycle.
REQ-028 Overlap: on channel 2 alone, drive j=1,0,1,1,0,1,1. Required response: two hit pulses with hit_id=10, and w[2] asserted after bit 4 and after bit 7.
REQ-029 Round-robin: hold req=1111 from reset. Required response: gnt sequence 0001, 0010, 0100, 1000, 0001; each channel detects 1011 only after its own four grants (16 cycles).
REQ-030 Starvation/hold: with req=0101, ptr=1, and channel 0 mid-pattern, channel 2 is granted first and channel 0's state holds until its own grant.
REQ-031 Reset mid-operation: with channel 1 in S3, pulse rst=0. Required response: w=0000 and hit=0 immediately; after release, bits 1 then 1 give no hit (the state goes S0->S1->S1).
REQ-032 With DETECT_CNT_EN: produce 300 detections. Required response: hit_cnt=255 and it does not wrap; after rst, hit_cnt=0.
